led_cmd_regfile: RTL and testbench

- Downstream consumer of the 7-bit serial-to-parallel command shifter.
- On each LATCH rising edge, decodes the parallel word (5-bit LED address, 2-bit instruction) and updates per-LED "active" and "pattern" state registers.
- Drives the 16 LED outputs as (pattern AND pattern_signal) OR active.
- pattern_signal is either the synchronised external PATTERN pin or an internal blink divider.

---
 rtl/led_ctrl_pkg.sv | 39 +++
 rtl/sync_edge.sv | 31 +++
 rtl/led_cmd_regfile.sv | 148 ++++++++++++++
 tb/tb_led_cmd_regfile.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared constants and command classification for the LED command register file.
package led_ctrl_pkg;

  localparam int unsigned CMD_W         = 7;
  localparam int unsigned ADDR_W        = 5;
  localparam int unsigned ADDR_LSB      = 0;
  localparam int unsigned BIT_ACTIVE    = 5;
  localparam int unsigned BIT_PATTERN   = 6;
  localparam logic [4:0]  ADDR_BROADCAST = 5'd31;

  localparam int unsigned DEF_BLINK_DIV = 500000;
  localparam int unsigned BLINK_CNT_W   = 24;

  typedef enum logic [1:0] {
    CmdNone,
    CmdLed,
    CmdBcast,
    CmdErr
  } cmd_kind_e;

  // Broadcast wins over the range check so a 32-LED build still broadcasts on 31.
  function automatic cmd_kind_e cmd_classify(input logic              rise,
                                             input logic [ADDR_W-1:0] addr,
                                             input int unsigned       n_leds);
    cmd_kind_e kind;
    kind = CmdNone;
    if (rise) begin
      if (addr == ADDR_BROADCAST) begin
        kind = CmdBcast;
      end else if (32'(addr) < n_leds) begin
        kind = CmdLed;
      end else begin
        kind = CmdErr;
      end
    end
    return kind;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchroniser for an asynchronous strobe; reports the synchronised
// level and a one-cycle pulse on its rising edge.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchroniser chain; s3 only serves edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/led_cmd_regfile.sv
// LED command register file: decodes latched command words into per-LED active
// and pattern bits and drives LED = (pattern & pattern_signal) | active.
module led_cmd_regfile #(
  parameter int unsigned N_LEDS        = 16,
  parameter int unsigned CMD_W         = led_ctrl_pkg::CMD_W,
  parameter int unsigned BLINK_DIV     = led_ctrl_pkg::DEF_BLINK_DIV,
  parameter bit          USE_INT_BLINK = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_latch,
  input  logic [CMD_W-1:0]  i_word,
  input  logic              i_pattern,
  output logic [N_LEDS-1:0] o_led,
  output logic              o_cmd_ack,
  output logic              o_cmd_err
);

  import led_ctrl_pkg::*;

  logic              w_latch_level;
  logic              w_latch_rise;
  logic [ADDR_W-1:0] w_addr;
  logic              w_a;
  logic              w_p;
  cmd_kind_e         w_kind;
  logic              w_pattern_sig;

  logic [N_LEDS-1:0] r_active;
  logic [N_LEDS-1:0] r_pattern;
  logic [N_LEDS-1:0] r_led;
  logic              r_ack;
  logic              r_err;

  logic [N_LEDS-1:0] w_active_d;
  logic [N_LEDS-1:0] w_pattern_d;
  logic              w_ack_d;
  logic              w_err_d;

  sync_edge u_latch_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_latch),
    .o_level (w_latch_level),
    .o_rise  (w_latch_rise)
  );

  assign w_addr = i_word[ADDR_LSB +: ADDR_W];
  assign w_a    = i_word[BIT_ACTIVE];
  assign w_p    = i_word[BIT_PATTERN];
  assign w_kind = cmd_classify(w_latch_rise & w_latch_level, w_addr, N_LEDS);

  // Next-state decode of the active/pattern registers and the ack/err pulses.
  always_comb begin
    w_active_d  = r_active;
    w_pattern_d = r_pattern;
    w_ack_d     = 1'b0;
    w_err_d     = 1'b0;
    unique case (w_kind)
      CmdLed: begin
        for (int i = 0; i < int'(N_LEDS); i++) begin
          if (w_addr == ADDR_W'(i)) begin
            w_active_d[i]  = w_a;
            w_pattern_d[i] = w_p;
          end
        end
        w_ack_d = 1'b1;
      end
      CmdBcast: begin
        w_active_d  = {N_LEDS{w_a}};
        w_pattern_d = {N_LEDS{w_p}};
        w_ack_d     = 1'b1;
      end
      CmdErr: begin
        w_err_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State registers and one-cycle command status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active  <= '0;
      r_pattern <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_active  <= w_active_d;
      r_pattern <= w_pattern_d;
      r_ack     <= w_ack_d;
      r_err     <= w_err_d;
    end
  end

  if (USE_INT_BLINK) begin : g_blink
    localparam logic [BLINK_CNT_W-1:0] BlinkLast = BLINK_CNT_W'(BLINK_DIV - 1);

    logic [BLINK_CNT_W-1:0] r_blink_cnt;
    logic                   r_blink_phase;

    // Free-running half-period counter; phase flips on each wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (r_blink_cnt == BlinkLast) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + 1'b1;
      end
    end

    assign w_pattern_sig = r_blink_phase;
  end else begin : g_pat_pin
    logic r_pat_s1;
    logic r_pat_s2;

    // Two-flop synchroniser for the external pattern pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_pat_s1 <= 1'b0;
        r_pat_s2 <= 1'b0;
      end else begin
        r_pat_s1 <= i_pattern;
        r_pat_s2 <= r_pat_s1;
      end
    end

    assign w_pattern_sig = r_pat_s2;
  end

  // Registered LED drive; active overrides the pattern gate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= (r_pattern & {N_LEDS{w_pattern_sig}}) | r_active;
    end
  end

  assign o_led     = r_led;
  assign o_cmd_ack = r_ack;
  assign o_cmd_err = r_err;

endmodule

// File: tb/tb_led_cmd_regfile.sv
// Directed bench for led_cmd_regfile: pin-pattern instance plus an internal
// blink instance (BLINK_DIV=4) sharing clock and reset.
module tb_led_cmd_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        latch, latch_b, pattern;
  logic [6:0]  word, word_b;
  logic [15:0] led, led_b;
  logic        ack, err, ack_b, err_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_cmd_regfile #(
    .N_LEDS        (16),
    .CMD_W         (7),
    .BLINK_DIV     (500000),
    .USE_INT_BLINK (1'b0)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_latch   (latch),
    .i_word    (word),
    .i_pattern (pattern),
    .o_led     (led),
    .o_cmd_ack (ack),
    .o_cmd_err (err)
  );

  led_cmd_regfile #(
    .N_LEDS        (16),
    .CMD_W         (7),
    .BLINK_DIV     (4),
    .USE_INT_BLINK (1'b1)
  ) dut_blk (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_latch   (latch_b),
    .i_word    (word_b),
    .i_pattern (pattern),
    .o_led     (led_b),
    .o_cmd_ack (ack_b),
    .o_cmd_err (err_b)
  );

  // One command on the pin-pattern instance, checking the k+1/k+2/k+3 timeline.
  task automatic do_cmd(input logic [6:0] w, input logic exp_ack, input logic exp_err,
                        input logic [15:0] exp_led, input string name);
    @(negedge clk);
    word  = w;
    latch = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL %s_early ack=%b err=%b expected 0 0", name, ack, err);
    end
    @(negedge clk);
    total++;
    if (ack !== exp_ack || err !== exp_err) begin
      bad++;
      $display("FAIL %s_pulse ack=%b err=%b expected %b %b", name, ack, err, exp_ack, exp_err);
    end
    @(negedge clk);
    total++;
    if (ack !== 1'b0 || err !== 1'b0 || led !== exp_led) begin
      bad++;
      $display("FAIL %s_after ack=%b err=%b led=%h expected 0 0 %h", name, ack, err, led,
               exp_led);
    end
    latch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; latch = 1'b0; latch_b = 1'b0; pattern = 1'b0;
    word = '0; word_b = '0;
    repeat (3) @(negedge clk);
    total++;
    if (led !== 16'h0 || ack !== 1'b0 || err !== 1'b0 || led_b !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold led=%h ack=%b err=%b led_b=%h expected 0", led, ack, err, led_b);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (led !== 16'h0 || ack !== 1'b0 || err !== 1'b0 || ack_b !== 1'b0 ||
          err_b !== 1'b0 || led_b !== 16'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d led=%h ack=%b err=%b led_b=%h expected all 0",
                 i, led, ack, err, led_b);
      end
    end
  endtask

  task automatic test_single_set();
    do_cmd(7'b01_00011, 1'b1, 1'b0, 16'h0008, "set3");
    do_cmd(7'b00_00011, 1'b1, 1'b0, 16'h0000, "clr3");
  endtask

  task automatic test_pattern();
    logic ph [0:39];
    logic [15:0] exp;
    do_cmd(7'b10_00101, 1'b1, 1'b0, 16'h0000, "pat5");
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      exp = (t >= 3 && ph[t-3]) ? 16'h0020 : 16'h0000;
      total++;
      if (led !== exp) begin
        bad++;
        $display("FAIL pattern_follow t=%0d led=%h expected %h", t, led, exp);
      end
      pattern = ((t / 10) % 2) == 1;
      ph[t]   = pattern;
    end
    pattern = 1'b0;
    repeat (4) @(negedge clk);
    do_cmd(7'b11_00101, 1'b1, 1'b0, 16'h0020, "patact5");
    for (int t = 0; t < 12; t++) begin
      pattern = ((t / 3) % 2) == 1;
      @(negedge clk);
      total++;
      if (led !== 16'h0020) begin
        bad++;
        $display("FAIL pattern_forced t=%0d led=%h expected 0020", t, led);
      end
    end
    pattern = 1'b0;
    repeat (4) @(negedge clk);
    do_cmd(7'b00_00101, 1'b1, 1'b0, 16'h0000, "clr5");
  endtask

  task automatic test_bcast_err();
    do_cmd(7'b01_11111, 1'b1, 1'b0, 16'hFFFF, "bcast");
    do_cmd(7'b00_10100, 1'b0, 1'b1, 16'hFFFF, "err20");
    do_cmd(7'b00_10000, 1'b0, 1'b1, 16'hFFFF, "err16");
    do_cmd(7'b00_01111, 1'b1, 1'b0, 16'h7FFF, "clr15");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    word  = 7'b01_00001;
    latch = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    latch = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (led !== 16'h0 || ack !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL midreset_hold led=%h ack=%b err=%b expected 0 0 0", led, ack, err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (led !== 16'h0 || ack !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL midreset_after cyc=%0d led=%h ack=%b err=%b expected 0 0 0",
                 i, led, ack, err);
      end
    end
    do_cmd(7'b01_00001, 1'b1, 1'b0, 16'h0002, "post_reset");
  endtask

  task automatic test_int_blink();
    logic [15:0] prev, v, exp;
    bit          seen;
    @(negedge clk);
    word_b  = 7'b10_11111;
    latch_b = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (ack_b !== 1'b1 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL blink_ack ack=%b err=%b expected 1 0", ack_b, err_b);
    end
    @(negedge clk);
    latch_b = 1'b0;
    prev = led_b;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (led_b !== prev) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL blink_toggle led_b=%h stuck, expected a change within 10 cycles", led_b);
    end
    v = led_b;
    total++;
    if (v !== 16'hFFFF && v !== 16'h0000) begin
      bad++;
      $display("FAIL blink_value led_b=%h expected ffff or 0000", v);
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      exp = (((j / 4) % 2) == 1) ? ~v : v;
      total++;
      if (led_b !== exp) begin
        bad++;
        $display("FAIL blink_period j=%0d led_b=%h expected %h", j, led_b, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_pattern();
    test_bcast_err();
    test_reset_mid();
    test_int_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
